// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extension unit: mode encodings and buffer depth.
package imm_ext_pkg;

  // Extension mode encodings carried on the mode port.
  typedef enum logic [1:0] {
    MODE_ZERO = 2'b00,
    MODE_SIGN = 2'b01,
    MODE_HIGH = 2'b10,
    MODE_RSVD = 2'b11
  } imm_mode_e;

  // Number of result slots between the extender and the consumer.
  localparam int unsigned IMM_FIFO_DEPTH = 2;

  // Width of the occupancy counter; must hold the value IMM_FIFO_DEPTH.
  localparam int unsigned IMM_CNT_W = 2;

endpackage : imm_ext_pkg

// File: rtl/imm_skid_fifo.sv
// Two-entry result buffer. Ready is derived from registered occupancy only, so the
// producer side never sees a combinational path from the consumer's ready.
module imm_skid_fifo
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_W = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid_i,
  output logic              push_ready_o,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              pop_valid_o,
  input  logic              pop_ready_i,
  output logic [DATA_W-1:0] pop_data_o
);

  localparam int unsigned DEPTH = IMM_FIFO_DEPTH;
  localparam int unsigned CNT_W = IMM_CNT_W;

  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              init_q;
  logic              push, pop;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Handshake outputs come straight from registered state; init_q holds ready low
  // until the first edge after reset is released.
  assign push_ready_o = init_q && (count_q < CNT_W'(DEPTH));
  assign pop_valid_o  = (count_q != '0);
  assign pop_data_o   = pop_valid_o ? mem_q[rd_ptr_q] : '0;

  // Next-state for occupancy and pointers from the two handshakes.
  always_comb begin
    push     = push_valid_i && push_ready_o;
    pop      = pop_valid_o && pop_ready_i;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous clear; reset drops every buffered entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      init_q   <= 1'b1;
    end
  end

  // Payload storage needs no reset: the read port is gated while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule : imm_skid_fifo

// File: rtl/imm_ext_unit.sv
// Immediate extender: zero/sign/high-half extension computed combinationally on
// acceptance, results buffered in a two-entry FIFO for a one-cycle latency.
module imm_ext_unit
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam int unsigned ENTRY_W = OUT_W + 1;

  logic [OUT_W-1:0]   ext_c;
  logic               err_c;
  logic [ENTRY_W-1:0] head;

  // Extension of the offered immediate; reserved mode yields the sign result flagged.
  always_comb begin
    ext_c = '0;
    err_c = 1'b0;
    unique case (imm_mode_e'(mode))
      MODE_ZERO: ext_c = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_SIGN: ext_c = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      MODE_HIGH: ext_c = OUT_W'({imm, {IN_W{1'b0}}});
      MODE_RSVD: begin
        ext_c = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        err_c = 1'b1;
      end
      default: begin
        ext_c = '0;
        err_c = 1'b0;
      end
    endcase
  end

  imm_skid_fifo #(
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (in_valid),
    .push_ready_o (in_ready),
    .push_data_i  ({err_c, ext_c}),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .pop_data_o   (head)
  );

  assign out_err  = head[OUT_W];
  assign out_data = head[OUT_W-1:0];

endmodule : imm_ext_unit

// File: tb/tb_imm_ext_unit.sv
// Directed bench for imm_ext_unit: extension modes, backpressure, streaming, async reset.
module tb_imm_ext_unit;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;

  int tests;
  int fails;

  imm_ext_unit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm       (imm),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence is a fixed number of cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    imm       = 16'hDEAD;
    mode      = 2'b01;
    out_ready = 1'b1;

    // Reset: outputs cleared, in_valid ignored.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);

    // Release: ready stays low until the first edge, so the offer is not taken.
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rel_in_ready_post", 32'(in_ready),  32'd1);
    chk("rel_no_accept",     32'(out_valid), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);

    // SIGN 8001.
    in_valid = 1'b1; imm = 16'h8001; mode = 2'b01;
    @(negedge clk);
    chk("sign_valid", 32'(out_valid), 32'd1);
    chk("sign_data",  out_data,       32'hFFFF8001);
    chk("sign_err",   32'(out_err),   32'd0);
    // ZERO 8001, pushed while the previous result pops.
    imm = 16'h8001; mode = 2'b00;
    @(negedge clk);
    chk("zero_data", out_data,     32'h00008001);
    chk("zero_err",  32'(out_err), 32'd0);
    // HIGH 1234.
    imm = 16'h1234; mode = 2'b10;
    @(negedge clk);
    chk("high_data", out_data,     32'h12340000);
    chk("high_err",  32'(out_err), 32'd0);
    // RSVD 7FFF.
    imm = 16'h7FFF; mode = 2'b11;
    @(negedge clk);
    chk("rsvd_data", out_data,     32'h00007FFF);
    chk("rsvd_err",  32'(out_err), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_data",  out_data,       32'd0);
    chk("drain_err",   32'(out_err),   32'd0);

    // Backpressure: A, B fill the FIFO, C is held off.
    out_ready = 1'b0;
    in_valid = 1'b1; imm = 16'h000A; mode = 2'b00;
    @(negedge clk);
    chk("bp_a_ready", 32'(in_ready), 32'd1);
    chk("bp_a_head",  out_data,      32'h0000000A);
    imm = 16'h000B;
    @(negedge clk);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_full_head",  out_data,      32'h0000000A);
    imm = 16'h000C;
    @(negedge clk);
    chk("bp_hold_ready", 32'(in_ready),  32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_head",  out_data,       32'h0000000A);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_b",   out_data,      32'h0000000B);
    chk("bp_b_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp_pop_c", out_data, 32'h0000000C);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Ten-beat stream with out_ready held: one result per cycle.
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; imm = 16'(16'h0100 + k); mode = 2'b00;
      @(negedge clk);
      chk("str_in_ready",  32'(in_ready),  32'd1);
      chk("str_out_valid", 32'(out_valid), 32'd1);
      chk("str_data",      out_data,       32'(32'h0100 + k));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("str_end", 32'(out_valid), 32'd0);

    // Async reset with two entries buffered.
    out_ready = 1'b0;
    in_valid = 1'b1; imm = 16'h0AAA; mode = 2'b00;
    @(negedge clk);
    imm = 16'h0BBB;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_data",  out_data,       32'd0);
    chk("ar_ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ar_no_stale", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b1; imm = 16'h0CCC; mode = 2'b00;
    @(negedge clk);
    chk("ar_fresh", out_data, 32'h00000CCC);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ar_fresh_drain", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_imm_ext_unit

// File: doc/imm_ext_unit.md
IMM_EXT_UNIT -- requirements
Module: imm_ext_unit

Interface
REQ-001 The block SHALL have parameter IN_W, default 16, meaning immediate input width in bits.
REQ-002 The block SHALL have parameter OUT_W, default 32, meaning extended output width in bits; legal only when OUT_W >= 2*IN_W.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the producer offers imm and mode.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts the input this cycle.
REQ-007 The block SHALL have port imm, input, IN_W bits, the raw immediate.
REQ-008 The block SHALL have port mode, input, 2 bits, the extension mode.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning out_data and out_err hold a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result this cycle.
REQ-011 The block SHALL have port out_data, output, OUT_W bits, the extended result.
REQ-012 The block SHALL have port out_err, output, 1 bit, meaning the result came from a reserved mode.

Function
REQ-013 Mode ZERO (00) SHALL produce {(OUT_W-IN_W) zeros, imm}.
REQ-014 Mode SIGN (01) SHALL produce {(OUT_W-IN_W) copies of imm[IN_W-1], imm}.
REQ-015 Mode HIGH (10) SHALL produce imm placed at bits [2*IN_W-1:IN_W], all other bits zero (DLX LHI form).
REQ-016 Mode RSVD (11) SHALL produce the SIGN result with out_err=1; out_err SHALL be 0 for every other mode.
REQ-017 An input SHALL be accepted exactly on a cycle where in_valid=1 and in_ready=1; the result and error bit SHALL be computed from that cycle's imm and mode and pushed into a 2-entry result FIFO.
REQ-018 Latency SHALL be 1 cycle: a result accepted at edge N into an empty FIFO SHALL show out_valid=1 after edge N.
REQ-019 A result SHALL be popped exactly on a cycle where out_valid=1 and out_ready=1.
REQ-020 out_valid SHALL equal (count != 0); out_data and out_err SHALL be the FIFO head and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 in_ready SHALL equal (count < 2), driven from registered state only, with no combinational path from out_ready.
REQ-022 Simultaneous push and pop at count=1 SHALL leave count=1 with the pushed entry becoming the head after the pop.
REQ-023 Simultaneous push and pop at count=0 SHALL not occur, because out_valid=0; at count=2 no push SHALL occur, and a pop SHALL give count=1.
REQ-024 Results SHALL leave in acceptance order; sustained throughput SHALL be 1 result per cycle when out_ready is held at 1.
REQ-025 Read and write pointers SHALL be 1 bit each and wrap from 1 to 0; count SHALL be 2 bits and never exceed 2.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately clear count and both pointers, forcing out_valid=0, in_ready=0, out_data=0 and out_err=0.
REQ-027 During reset, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-028 The first rising clk edge after rst_n deasserts SHALL set in_ready=1.
REQ-029 Reset mid-transfer SHALL discard all buffered results; results dropped this way SHALL never appear at the output.
REQ-030 FIFO data storage SHALL need no reset; out_data SHALL be gated to 0 while count=0.

Structure
REQ-031 Mode encodings MODE_ZERO, MODE_SIGN, MODE_HIGH and MODE_RSVD SHALL reside in shared package imm_ext_pkg.
REQ-032 The package SHALL also hold FIFO depth constant IMM_FIFO_DEPTH=2.
REQ-033 The extension logic SHALL stay combinational inside imm_ext_unit.
REQ-034 Buffering SHALL be one sub-module, imm_skid_fifo, parametrised by data width (OUT_W+1).

Verification
REQ-035 Bench SHALL check: after reset release, mode=01 and imm=16'h8001 -> out_data=32'hFFFF8001, out_err=0, one cycle after acceptance.
REQ-036 Bench SHALL check: mode=00 with imm=16'h8001 -> 32'h00008001; mode=10 with imm=16'h1234 -> 32'h12340000.
REQ-037 Bench SHALL check: mode=11 with imm=16'h7FFF -> out_data=32'h00007FFF, out_err=1.
REQ-038 Bench SHALL check: out_ready=0 while pushing A, B and C back-to-back -> in_ready=0 after the second accept; C is held off; out_data stays A; releasing out_ready yields A, B, C in order.
REQ-039 Bench SHALL check: out_ready=1 with a 10-beat continuous stream -> 10 results on 10 consecutive cycles, and in_ready never drops.
REQ-040 Bench SHALL check: rst_n pulled low asynchronously with 2 entries buffered -> out_valid=0 before the next clk edge; no stale entry emerges after release.
